// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Two-digit seven-segment scan controller. The raw 4-bit switch value is
//   synchronised and debounced, split into tens/units, and both digits are
//   time-multiplexed onto one shared active-low segment bus. An all-off guard
//   interval between digit slots prevents ghosting.
//
// Parameters
//   REFRESH_DIV  cycles each digit is lit per slot (>= 2)
//   DEBOUNCE     cycles the synchronised switches must be stable (>= 1)
//   BLANK_GAP    cycles with both anodes off between slots (0 = no gap)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   sw     in   [3:0] raw switch value, asynchronous to clk
//   blank  in   1 = force both anodes off (scan keeps running internally)
//   lz_en  in   1 = blank the tens digit when it is 0
//   seg    out  [6:0] active-low segments, seg[6]=a .. seg[0]=g
//   an     out  [1:0] active-low anodes, an[0]=units, an[1]=tens
//   value  out  [3:0] debounced latched switch value
//   upd    out  one-cycle pulse when value changes
module disp_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEBOUNCE    = 500000,
  parameter int unsigned BLANK_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       blank,
  input  logic       lz_en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] value,
  output logic       upd
);

  localparam int unsigned SC_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(DEBOUNCE - 1);

  localparam int unsigned SLOT_MAX = (REFRESH_DIV > BLANK_GAP) ? REFRESH_DIV : BLANK_GAP;
  localparam int unsigned RC_W     = $clog2(SLOT_MAX);
  localparam logic [RC_W-1:0] SLOT_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [RC_W-1:0] GAP_LAST  = (BLANK_GAP > 0) ? RC_W'(BLANK_GAP - 1) : '0;
  localparam bit HAS_GAP = (BLANK_GAP > 0);

  typedef enum logic [1:0] {
    UNITS_ON,
    GAP_TU,
    TENS_ON,
    GAP_UT
  } scan_state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic [3:0]      sync_q;
  logic [3:0]      sw_s;
  logic [3:0]      cand;
  logic [SC_W-1:0] scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sw_s   <= '0;
    end else begin
      sync_q <= sw;
      sw_s   <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= '0;
      scnt  <= '0;
      value <= '0;
      upd   <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (sw_s != cand) begin
        cand <= sw_s;
        scnt <= '0;
      end else if (scnt < SC_LAST) begin
        scnt <= scnt + SC_W'(1);
      end else if (cand != value) begin
        value <= cand;
        upd   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Binary to tens/units
  // ---------------------------------------------------------------------------
  logic       tens;
  logic [3:0] units;

  always_comb begin
    tens  = (value >= 4'd10);
    units = tens ? (value - 4'd10) : value;
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  scan_state_t     state, state_n;
  logic [RC_W-1:0] rcnt, rcnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GAP_UT;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt + RC_W'(1);
    case (state)
      UNITS_ON: begin
        if (rcnt == SLOT_LAST) begin
          state_n = HAS_GAP ? GAP_TU : TENS_ON;
          rcnt_n  = '0;
        end
      end
      GAP_TU: begin
        if (rcnt == GAP_LAST) begin
          state_n = TENS_ON;
          rcnt_n  = '0;
        end
      end
      TENS_ON: begin
        if (rcnt == SLOT_LAST) begin
          state_n = HAS_GAP ? GAP_UT : UNITS_ON;
          rcnt_n  = '0;
        end
      end
      GAP_UT: begin
        if (!HAS_GAP) begin
          // Without a gap, the reset GAP_UT cycle is already shown as the
          // first units cycle, so the units slot starts one count in.
          state_n = UNITS_ON;
          rcnt_n  = RC_W'(1);
        end else if (rcnt == GAP_LAST) begin
          state_n = UNITS_ON;
          rcnt_n  = '0;
        end
      end
      default: begin
        state_n = GAP_UT;
        rcnt_n  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered display outputs
  // ---------------------------------------------------------------------------
  scan_state_t disp_state;
  logic [6:0]  seg_n;
  logic [1:0]  an_n;

  always_comb begin
    disp_state = state;
    if (!HAS_GAP && (state == GAP_UT)) begin
      disp_state = UNITS_ON;
    end
    an_n  = 2'b11;
    seg_n = '1;
    if (!blank) begin
      case (disp_state)
        UNITS_ON: begin
          an_n  = 2'b10;
          seg_n = seg_code(units);
        end
        TENS_ON: begin
          an_n = 2'b01;
          if (!(lz_en && !tens)) begin
            seg_n = seg_code({3'b000, tens});
          end
        end
        default: begin
          an_n  = 2'b11;
          seg_n = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 2'b11;
      seg <= '1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl with REFRESH_DIV=4, DEBOUNCE=3, BLANK_GAP=1.
// Stimulus pushes expected display/value entries (tagged with the edge number
// counted from reset release) and expected upd pulses into queues; a monitor
// on the falling edge pops and compares them.
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       blank;
  logic       lz_en;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] value;
  logic       upd;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  disp_scan_ctrl #(
    .REFRESH_DIV(4),
    .DEBOUNCE   (3),
    .BLANK_GAP  (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .blank(blank),
    .lz_en(lz_en),
    .seg  (seg),
    .an   (an),
    .value(value),
    .upd  (upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    int         e;
    logic [1:0] an;
    logic [6:0] seg;
    bit         cseg;
    logic [3:0] val;
    bit         cval;
  } disp_t;

  typedef struct {
    int         e;
    logic [3:0] val;
  } upd_t;

  disp_t dq[$];
  upd_t  uq[$];

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] SOFF = 7'b1111111;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b exp=%b", name, edge_n, got, exp);
    end
  endtask

  task automatic push_disp(input int e, input logic [1:0] a, input logic [6:0] s,
                           input bit cs, input bit cv, input logic [3:0] v);
    disp_t d;
    d.e = e; d.an = a; d.seg = s; d.cseg = cs; d.val = v; d.cval = cv;
    dq.push_back(d);
  endtask

  // Steady-state slot pattern after release: edge%10 in {1,6} gap,
  // {2..5} units lit, {7,8,9,0} tens lit.
  task automatic push_sched(input int e0, input int e1, input logic [6:0] us,
                            input logic [6:0] ts, input bit cs, input bit cv,
                            input logic [3:0] v);
    for (int e = e0; e <= e1; e++) begin
      int r;
      r = e % 10;
      if (r == 1 || r == 6)      push_disp(e, 2'b11, SOFF, cs, cv, v);
      else if (r >= 2 && r <= 5) push_disp(e, 2'b10, us, cs, cv, v);
      else                       push_disp(e, 2'b01, ts, cs, cv, v);
    end
  endtask

  task automatic push_upd(input int e, input logic [3:0] v);
    upd_t u;
    u.e = e; u.val = v;
    uq.push_back(u);
  endtask

  task automatic to_edge(input int n);
    int g;
    g = 0;
    while (edge_n < n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (edge_n != n) begin
      failures++;
      $display("FAIL to_edge got=%0d exp=%0d", edge_n, n);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("an_overlap", {7'd0, (an == 2'b00)}, 8'd0);
      while (dq.size() > 0 && dq[0].e < edge_n) begin
        checks++;
        failures++;
        $display("FAIL disp_missed got=%0d exp=%0d", edge_n, dq[0].e);
        void'(dq.pop_front());
      end
      while (dq.size() > 0 && dq[0].e == edge_n) begin
        chk("an", {6'd0, an}, {6'd0, dq[0].an});
        if (dq[0].cseg) chk("seg", {1'b0, seg}, {1'b0, dq[0].seg});
        if (dq[0].cval) chk("value", {4'd0, value}, {4'd0, dq[0].val});
        void'(dq.pop_front());
      end
      if (upd) begin
        if (uq.size() > 0 && uq[0].e == edge_n) begin
          chk("upd_value", {4'd0, value}, {4'd0, uq[0].val});
          void'(uq.pop_front());
        end else begin
          checks++;
          failures++;
          $display("FAIL upd_unexpected edge=%0d got=1 exp=0 value=%0d", edge_n, value);
        end
      end else if (uq.size() > 0 && uq[0].e <= edge_n) begin
        checks++;
        failures++;
        $display("FAIL upd_missing edge=%0d got=0 exp=1 at edge %0d", edge_n, uq[0].e);
        void'(uq.pop_front());
      end
    end
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    sw    = 4'hF;
    blank = 1'b0;
    lz_en = 1'b0;

    // Reset with switches high
    repeat (3) @(negedge clk);
    chk("rst_an",    {6'd0, an},    8'h03);
    chk("rst_seg",   {1'b0, seg},   8'h7F);
    chk("rst_value", {4'd0, value}, 8'h00);
    chk("rst_upd",   {7'd0, upd},   8'h00);
    @(negedge clk);
    #2;
    sw    = 4'h0;
    rst_n = 1'b1;
    push_sched(1, 21, S0, S0, 1'b1, 1'b1, 4'd0);

    // Debounce 0 -> 13
    to_edge(22);
    sw = 4'd13;
    push_upd(28, 4'd13);
    push_sched(22, 27, S0, S0, 1'b1, 1'b1, 4'd0);
    push_sched(28, 28, S0, S0, 1'b1, 1'b1, 4'd13);
    push_sched(29, 40, S3, S1, 1'b1, 1'b1, 4'd13);

    // Two-cycle glitch to 7
    to_edge(41);
    sw = 4'd7;
    to_edge(43);
    sw = 4'd13;
    push_sched(44, 50, S3, S1, 1'b1, 1'b1, 4'd13);

    // Leading zero with value 5
    to_edge(51);
    sw = 4'd5;
    push_upd(57, 4'd5);
    push_sched(51, 56, S3, S1, 1'b1, 1'b1, 4'd13);
    push_sched(57, 57, S3, S1, 1'b1, 1'b1, 4'd5);
    push_sched(58, 60, S5, S0, 1'b1, 1'b1, 4'd5);
    to_edge(60);
    lz_en = 1'b1;
    push_sched(61, 70, S5, SOFF, 1'b1, 1'b1, 4'd5);
    to_edge(71);
    lz_en = 1'b0;
    push_sched(71, 80, S5, S0, 1'b1, 1'b1, 4'd5);

    // Blank during units slot
    to_edge(81);
    blank = 1'b1;
    push_sched(81, 81, S5, S0, 1'b1, 1'b1, 4'd5);
    for (int e = 82; e <= 84; e++) push_disp(e, 2'b11, SOFF, 1'b1, 1'b1, 4'd5);
    push_sched(85, 90, S5, S0, 1'b1, 1'b1, 4'd5);
    to_edge(84);
    blank = 1'b0;

    // Sweep 0..15 over 200 cycles, anode pattern only
    to_edge(91);
    push_sched(91, 291, SOFF, SOFF, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      to_edge(91 + 12 * i);
      sw = 4'(i);
      push_upd(97 + 12 * i, 4'(i));
    end

    // Mid-run reset with candidate 3 pending during tens slot
    to_edge(296);
    sw = 4'd3;
    to_edge(300);
    #3;
    rst_n = 1'b0;
    sw    = 4'd0;
    #1;
    chk("mid_rst_an",    {6'd0, an},    8'h03);
    chk("mid_rst_seg",   {1'b0, seg},   8'h7F);
    chk("mid_rst_value", {4'd0, value}, 8'h00);
    chk("mid_rst_upd",   {7'd0, upd},   8'h00);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    push_sched(1, 25, S0, S0, 1'b1, 1'b1, 4'd0);
    to_edge(26);
    @(negedge clk);

    chk("disp_queue_left", 8'(dq.size()), 8'd0);
    chk("upd_queue_left",  8'(uq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the two-digit seven-segment display on the board. It debounces the 4-bit switch input and converts the latched value (0–15) to tens/units. It then time-multiplexes both digits onto one shared active-low segment bus by sequencing the two anodes, inserting an all-off guard interval between digits to prevent ghosting. This replaces the static single-digit-select scheme and drives the display pins directly.

## Interface

- REFRESH_DIV, 50000, clock cycles each digit is lit per slot (≥2)
- DEBOUNCE, 500000, clock cycles the synchronized switches must be stable before latching (≥1)
- BLANK_GAP, 4, cycles with both anodes off between digit slots (0 = no gap)

- clk  in  1  system clock, all flops rising-edge
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  raw switch value, asynchronous to clk
- blank  in  1  1 = force both anodes off; scanning continues internally
- lz_en  in  1  1 = blank tens digit when it is 0
- seg  out  7  active-low segments, seg[6]=a … seg[0]=g
- an  out  2  active-low anodes, an[0]=units, an[1]=tens
- value  out  4  debounced latched switch value
- upd  out  1  one-cycle pulse when value changes

## Operation

- Input path: 2-FF synchronizer on sw gives sw_s. Candidate register cand and stable counter scnt:
  - If sw_s≠cand: cand←sw_s, scnt←0.
  - Else if scnt<DEBOUNCE-1: scnt increments.
  - Else scnt holds. If cand≠value, then value←cand and upd←1 for that cycle.
  - upd=0 in all other cycles.
  - A glitch shorter than DEBOUNCE cycles never reaches value.
- BCD: tens = (value≥10); units = value−10 if value≥10, else value. Width: tens is 1 bit, units is 4 bits. Units is always 0–9.
- Segment code (active-low, abcdefg), from 0 to 9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. A blanked digit is 1111111.
- Scan FSM, states UNITS_ON, GAP_TU, TENS_ON, GAP_UT, with slot counter rcnt:
  - UNITS_ON: an=10, seg=code(units). After REFRESH_DIV cycles go to GAP_TU.
  - GAP_TU: an=11, seg=1111111. After BLANK_GAP cycles go to TENS_ON.
  - TENS_ON: an=01. seg=1111111 if lz_en and tens=0, else code(tens). After REFRESH_DIV cycles go to GAP_UT.
  - GAP_UT: an=11, seg=1111111. After BLANK_GAP cycles go to UNITS_ON.
  - BLANK_GAP=0: the gap states are skipped. UNITS_ON and TENS_ON alternate directly.
  - rcnt resets to 0 on every state change.
- blank=1 forces an=11 and seg=1111111 on the next edge. The FSM and counters are unaffected. Releasing blank resumes the current slot mid-count.
- A value change takes effect on seg in the cycle after it latches, even mid-slot. There is no slot realignment.
- The anode pattern is never 00, in any cycle or mode.

## Timing

- Reset (rst_n=0, async): an=11, seg=1111111, value=0, upd=0, cand=0, scnt=0, synchronizer=0, state=GAP_UT, rcnt=0.
- After rst_n deasserts, the first UNITS_ON output appears BLANK_GAP+1 edges later (1 edge if BLANK_GAP=0).
- seg and an are registered and reflect the FSM state, value, blank and lz_en sampled at the same edge.
- Switch latency: a stable change on sw at edge 0 gives value and upd at edge DEBOUNCE+3.
- Reset asserted mid-slot or mid-debounce aborts immediately to the reset values. A pending candidate is discarded.
- Display period is 2·(REFRESH_DIV+BLANK_GAP) cycles. Each anode's duty is REFRESH_DIV/period.

## Test plan

Bench parameters for all scenarios: REFRESH_DIV=4, DEBOUNCE=3, BLANK_GAP=1.

- Reset: hold rst_n=0 with sw=4'hF → an=11, seg=1111111, value=0, upd=0. Release → an=10 with seg=0000001 at edge 2. Then units is lit for 4 cycles, gap 1, tens lit for 4 (0000001, lz_en=0), gap 1, repeating.
- Debounce: sw 0→13 at edge 0 → value=13 and upd=1 at edge 6 only. Then tens slot seg=1001111 and units slot seg=0000110. A 2-cycle pulse to 7 gives no value change and no upd.
- Leading zero: value=5 with lz_en=1 → tens slot an=01 and seg=1111111, units slot seg=0100100. With lz_en=0 the tens slot shows 0000001.
- Blank: assert blank during UNITS_ON for 3 cycles → an=11 on those edges. On release, the remaining units cycles complete and the slot boundary is unchanged versus a no-blank run.
- Gap and overlap: sweep value 0–15 over 200 cycles. Check an is never 00, every UNITS_ON/TENS_ON transition passes exactly 1 cycle of an=11, and each lit slot is exactly 4 cycles.
- Mid-run reset: assert rst_n=0 asynchronously (between clock edges) during TENS_ON with a candidate pending → all outputs are at reset values before the next edge. After release, the previous candidate is not latched.
